mem_access: RTL and testbench

Memory-access stage directly downstream of the ALU. It takes the ALU's registered `result` as the effective byte address for loads and stores. It drives a single-outstanding request/grant data-memory port, generates byte strobes and replicated store data, and sign- or zero-extends load data. Non-memory instructions pass the ALU result straight through to writeback.

---
 rtl/mem_access_pkg.sv | 119 +++++++++++
 rtl/mem_access_load_extend.sv | 31 +++
 rtl/mem_access.sv | 178 +++++++++++++++++
 tb/tb_mem_access.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
//
// Contents:
//   instructions - decoded-instruction flags coming from the decoder
//   regvpair     - source operand values (rs1, rs2)
//   mem_op_t     - memory operation kind (NONE, LOAD, STORE)
//   ext_t        - access size / load extension (SB, SH, SW, UB, UH)
//   state_t      - mem_access FSM state encoding
//   helpers      - memory-op decode, alignment test, store lanes and data
package mem_access_pkg;

    typedef struct packed {
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic branch;
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
        logic addi;
        logic add;
        logic sub;
        logic alu_other;
    } instructions;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
    } regvpair;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        STORE
    } mem_op_t;

    // SB/SH/SW double as the size of a store; UB/UH only occur for loads.
    typedef enum logic [2:0] {
        SB,
        SH,
        SW,
        UB,
        UH
    } ext_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R
    } state_t;

    typedef struct packed {
        mem_op_t op;
        ext_t    ext;
    } mem_decode_t;

    // Only the eight load/store flags are looked at; anything else is NONE.
    function automatic mem_decode_t decode_mem(input instructions i);
        mem_decode_t d;
        d.op  = NONE;
        d.ext = SW;
        if (i.lb) begin
            d.op = LOAD;  d.ext = SB;
        end else if (i.lh) begin
            d.op = LOAD;  d.ext = SH;
        end else if (i.lw) begin
            d.op = LOAD;  d.ext = SW;
        end else if (i.lbu) begin
            d.op = LOAD;  d.ext = UB;
        end else if (i.lhu) begin
            d.op = LOAD;  d.ext = UH;
        end else if (i.sb) begin
            d.op = STORE; d.ext = SB;
        end else if (i.sh) begin
            d.op = STORE; d.ext = SH;
        end else if (i.sw) begin
            d.op = STORE; d.ext = SW;
        end
        return d;
    endfunction

    function automatic logic is_misaligned(input ext_t ext, input logic [1:0] lo);
        logic m;
        case (ext)
            SH, UH:  m = lo[0];
            SW:      m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] store_strobe(input ext_t ext, input logic [1:0] lo);
        logic [3:0] s;
        case (ext)
            SB:      s = 4'b0001 << lo;
            SH:      s = 4'b0011 << lo;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Data is replicated across all lanes so the strobes alone select the bytes.
    function automatic logic [31:0] store_data(input ext_t ext, input logic [31:0] rs2);
        logic [31:0] d;
        case (ext)
            SB:      d = {4{rs2[7:0]}};
            SH:      d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load data extraction: aligns the addressed byte/halfword of a read word
// down to bit 0 and sign- or zero-extends it.
//
// Ports:
//   m_rdata - 32-bit word returned by memory
//   addr    - low two bits of the byte address
//   ext     - access size and extension type
//   value   - extended 32-bit load result
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] m_rdata,
    input  logic [1:0]  addr,
    input  ext_t        ext,
    output logic [31:0] value
);

    logic [31:0] shifted;

    always_comb begin
        shifted = m_rdata >> {addr, 3'b000};
        case (ext)
            SB:      value = {{24{shifted[7]}}, shifted[7:0]};
            UB:      value = {24'h000000, shifted[7:0]};
            SH:      value = {{16{shifted[15]}}, shifted[15:0]};
            UH:      value = {16'h0000, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Uses the ALU result as the byte address of
// loads and stores, runs a single-outstanding request/grant data port, and
// passes non-memory results straight through to writeback.
//
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   enabled            - one-cycle start pulse, only honoured in IDLE
//   instr, register    - decoded instruction flags and operands (rs2 = store data)
//   alu_result         - effective address, or writeback value for non-memory ops
//   completed          - one-cycle pulse; result/misaligned valid with it
//   result, misaligned - writeback value and alignment fault flag
//   busy               - high whenever the FSM is not IDLE
//   m_req, m_we, m_addr, m_wdata, m_wstrb - request side of the memory port
//   m_gnt, m_rvalid, m_rdata             - grant and read-data response
//
// Handshake: m_req is raised with all request fields and they are held
// unchanged until the cycle m_gnt is sampled high; that cycle transfers the
// request. Read data is accepted in any later cycle where m_rvalid is high,
// and m_gnt/m_rvalid are ignored in every other state.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enabled,
    input  instructions           instr,
    input  regvpair               register,
    input  logic [31:0]           alu_result,
    output logic                  completed,
    output logic [31:0]           result,
    output logic                  misaligned,
    output logic                  busy,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [31:0]           m_rdata
);

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    ext_t                  ext_q, ext_d;
    mem_op_t               op_q, op_d;
    mem_decode_t           dec;
    logic [31:0]           load_value;

    logic                  completed_d, misaligned_d, m_req_d, m_we_d;
    logic [31:0]           result_d, m_wdata_d;
    logic [ADDR_WIDTH-1:0] m_addr_d;
    logic [3:0]            m_wstrb_d;

    // rs1 is part of the operand bundle but has no role in this stage.
    logic unused_rs1;
    assign unused_rs1 = ^register.rs1;

    assign busy = (state_q != IDLE);

    load_extend u_load_extend (
        .m_rdata (m_rdata),
        .addr    (addr_q[1:0]),
        .ext     (ext_q),
        .value   (load_value)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ext_d        = ext_q;
        op_d         = op_q;
        completed_d  = 1'b0;
        misaligned_d = 1'b0;
        result_d     = result;
        m_req_d      = m_req;
        m_we_d       = m_we;
        m_addr_d     = m_addr;
        m_wdata_d    = m_wdata;
        m_wstrb_d    = m_wstrb;
        dec          = decode_mem(instr);

        case (state_q)
            IDLE: begin
                if (enabled) begin
                    if (dec.op == NONE) begin
                        result_d    = alu_result;
                        completed_d = 1'b1;
                    end else if (is_misaligned(dec.ext, alu_result[1:0])) begin
                        // Faulting accesses never reach the bus.
                        result_d     = alu_result;
                        misaligned_d = 1'b1;
                        completed_d  = 1'b1;
                    end else begin
                        addr_d   = alu_result;
                        ext_d    = dec.ext;
                        op_d     = dec.op;
                        m_req_d  = 1'b1;
                        m_addr_d = alu_result[ADDR_WIDTH-1:0];
                        if (dec.op == STORE) begin
                            m_we_d    = 1'b1;
                            m_wdata_d = store_data(dec.ext, register.rs2);
                            m_wstrb_d = store_strobe(dec.ext, alu_result[1:0]);
                        end else begin
                            m_we_d    = 1'b0;
                            m_wdata_d = 32'h0;
                            m_wstrb_d = 4'b0000;
                        end
                        state_d = REQ;
                    end
                end
            end

            REQ: begin
                if (m_gnt) begin
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    m_wstrb_d = 4'b0000;
                    if (op_q == STORE) begin
                        result_d    = addr_q;
                        completed_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end

            WAIT_R: begin
                if (m_rvalid) begin
                    result_d    = load_value;
                    completed_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            ext_q      <= SW;
            op_q       <= NONE;
            completed  <= 1'b0;
            misaligned <= 1'b0;
            result     <= 32'h0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= 32'h0;
            m_wstrb    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ext_q      <= ext_d;
            op_q       <= op_d;
            completed  <= completed_d;
            misaligned <= misaligned_d;
            result     <= result_d;
            m_req      <= m_req_d;
            m_we       <= m_we_d;
            m_addr     <= m_addr_d;
            m_wdata    <= m_wdata_d;
            m_wstrb    <= m_wstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed steps followed by a randomized run against
// a byte-addressed memory model.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int OP_ADDI = 0, OP_ADD = 1, OP_LUI = 2;
    localparam int OP_LB = 3, OP_LH = 4, OP_LW = 5, OP_LBU = 6, OP_LHU = 7;
    localparam int OP_SB = 8, OP_SH = 9, OP_SW = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    instructions instr = '0;
    regvpair     register = '0;
    logic [31:0] alu_result = 32'h0;
    logic        m_gnt = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    logic        completed, misaligned, busy, m_req, m_we;
    logic [31:0] result, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    int n_assert = 0;
    int n_fail = 0;

    // bus_mem is written only through the DUT's strobes; ref_mem is written
    // directly from the store's size and rs2.
    logic [7:0] bus_mem [0:1023];
    logic [7:0] ref_mem [0:1023];

    mem_access #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enabled    (enabled),
        .instr      (instr),
        .register   (register),
        .alu_result (alu_result),
        .completed  (completed),
        .result     (result),
        .misaligned (misaligned),
        .busy       (busy),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_gnt      (m_gnt),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic instructions make_instr(input int code);
        instructions i;
        i = '0;
        case (code)
            OP_ADDI: i.addi = 1'b1;
            OP_ADD:  i.add  = 1'b1;
            OP_LUI:  i.lui  = 1'b1;
            OP_LB:   i.lb   = 1'b1;
            OP_LH:   i.lh   = 1'b1;
            OP_LW:   i.lw   = 1'b1;
            OP_LBU:  i.lbu  = 1'b1;
            OP_LHU:  i.lhu  = 1'b1;
            OP_SB:   i.sb   = 1'b1;
            OP_SH:   i.sh   = 1'b1;
            default: i.sw   = 1'b1;
        endcase
        return i;
    endfunction

    function automatic int op_size(input int code);
        if (code == OP_LB || code == OP_LBU || code == OP_SB) return 1;
        if (code == OP_LH || code == OP_LHU || code == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit op_load(input int code);
        return code >= OP_LB && code <= OP_LHU;
    endfunction

    function automatic bit op_store(input int code);
        return code >= OP_SB;
    endfunction

    function automatic logic [31:0] bus_word(input int a);
        int b;
        b = a & ~3;
        return {bus_mem[b+3], bus_mem[b+2], bus_mem[b+1], bus_mem[b]};
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input int code, input int a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < op_size(code); i++) v[8*i +: 8] = ref_mem[a+i];
        if (code == OP_LB && v[7])  v = v | 32'hFFFF_FF00;
        if (code == OP_LH && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input int code, input logic [31:0] rs2);
        if (code == OP_SB) return {4{rs2[7:0]}};
        if (code == OP_SH) return {2{rs2[15:0]}};
        return rs2;
    endfunction

    // One complete operation, with gnt_dly stall cycles before the grant and
    // rv_dly cycles between grant and read data. Stray m_rvalid during the
    // request phase and stray m_gnt while waiting for data must be ignored.
    task automatic run_op(input int code, input logic [31:0] addr, input logic [31:0] rs2,
                          input int gnt_dly, input int rv_dly);
        bit          is_mem, exp_mis;
        int          size, a, lo;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata, held_wdata;
        logic [3:0]  held_strb;

        is_mem  = op_load(code) || op_store(code);
        size    = op_size(code);
        a       = int'(addr[9:0]);
        lo      = a % 4;
        exp_mis = is_mem && (a % size != 0);

        instr        = make_instr(code);
        register.rs1 = $urandom;
        register.rs2 = rs2;
        alu_result   = addr;
        enabled      = 1'b1;
        step();
        enabled      = 1'b0;
        instr        = make_instr(OP_ADDI);
        alu_result   = $urandom;
        register     = {$urandom, $urandom};

        if (!is_mem || exp_mis) begin
            check("fast_completed", {31'b0, completed}, 32'd1);
            check("fast_result", result, addr);
            check("fast_misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
            check("fast_no_req", {31'b0, m_req}, 32'd0);
        end else begin
            check("issue_completed", {31'b0, completed}, 32'd0);
            check("issue_req", {31'b0, m_req}, 32'd1);
            check("issue_addr", m_addr, addr);
            check("issue_we", {31'b0, m_we}, {31'b0, op_store(code)});
            check("issue_busy", {31'b0, busy}, 32'd1);
            if (op_store(code)) begin
                exp_strb  = 4'((1 << size) - 1) << lo;
                exp_wdata = ref_wdata(code, rs2);
                check("store_wstrb", {28'b0, m_wstrb}, {28'b0, exp_strb});
                check("store_wdata", m_wdata, exp_wdata);
            end else begin
                check("load_wstrb", {28'b0, m_wstrb}, 32'd0);
            end
            held_wdata = m_wdata;
            held_strb  = m_wstrb;
            for (int k = 0; k < gnt_dly; k++) begin
                m_rvalid = 1'b1;
                m_rdata  = $urandom;
                step();
                m_rvalid = 1'b0;
                check("stall_req", {31'b0, m_req}, 32'd1);
                check("stall_addr", m_addr, addr);
                check("stall_wdata", m_wdata, held_wdata);
                check("stall_wstrb", {28'b0, m_wstrb}, {28'b0, held_strb});
                check("stall_completed", {31'b0, completed}, 32'd0);
            end
            if (op_store(code)) begin
                for (int i = 0; i < 4; i++)
                    if (m_wstrb[i]) bus_mem[(a & ~3) + i] = m_wdata[8*i +: 8];
                for (int i = 0; i < size; i++) ref_mem[a+i] = rs2[8*i +: 8];
            end
            m_gnt = 1'b1;
            step();
            m_gnt = 1'b0;
            check("gnt_req_dropped", {31'b0, m_req}, 32'd0);
            if (op_store(code)) begin
                check("store_completed", {31'b0, completed}, 32'd1);
                check("store_result", result, addr);
                check("store_misaligned", {31'b0, misaligned}, 32'd0);
                check("store_mem_word", bus_word(a), ref_word(a));
            end else begin
                check("wait_completed", {31'b0, completed}, 32'd0);
                for (int k = 0; k < rv_dly; k++) begin
                    m_gnt = 1'b1;
                    step();
                    m_gnt = 1'b0;
                    check("wait_completed", {31'b0, completed}, 32'd0);
                    check("wait_busy", {31'b0, busy}, 32'd1);
                end
                m_rvalid = 1'b1;
                m_rdata  = bus_word(a);
                step();
                m_rvalid = 1'b0;
                m_rdata  = $urandom;
                check("load_completed", {31'b0, completed}, 32'd1);
                check("load_result", result, ref_load(code, a));
                check("load_misaligned", {31'b0, misaligned}, 32'd0);
            end
        end
        step();
        check("pulse_completed", {31'b0, completed}, 32'd0);
        check("pulse_misaligned", {31'b0, misaligned}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_completed"}, {31'b0, completed}, 32'd0);
        check({tag, "_misaligned"}, {31'b0, misaligned}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_req"}, {31'b0, m_req}, 32'd0);
        check({tag, "_we"}, {31'b0, m_we}, 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_addr"}, m_addr, 32'd0);
        check({tag, "_wdata"}, m_wdata, 32'd0);
        check({tag, "_wstrb"}, {28'b0, m_wstrb}, 32'd0);
    endtask

    initial begin
        int          code, a, sz;
        logic [31:0] addr;

        for (int i = 0; i < 1024; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        // Word at 0x200 holds 0x0080_0000 for the extension tests.
        bus_mem[512] = 8'h00; bus_mem[513] = 8'h00; bus_mem[514] = 8'h80; bus_mem[515] = 8'h00;
        for (int i = 512; i < 516; i++) ref_mem[i] = bus_mem[i];

        // Reset state
        #1;
        check_reset_outputs("reset");
        step();
        step();
        #2 rstn = 1'b1;
        step();

        // Directed steps
        run_op(OP_ADDI, 32'h0000_1234, 32'h0, 0, 0);
        check("addi_result", result, 32'h0000_1234);

        run_op(OP_SB, 32'h0000_0103, 32'hAABB_CCDD, 3, 0);
        check("sb_mem_byte", {24'b0, bus_mem[259]}, 32'h0000_00DD);

        run_op(OP_LB, 32'h0000_0202, 32'h0, 0, 2);
        check("lb_result", result, 32'hFFFF_FF80);

        run_op(OP_LHU, 32'h0000_0202, 32'h0, 1, 0);
        check("lhu_result", result, 32'h0000_0080);

        run_op(OP_LW, 32'h0000_0201, 32'h0, 0, 0);
        check("lw_mis_result", result, 32'h0000_0201);

        run_op(OP_SH, 32'h0000_0300, 32'h1234_5678, 0, 0);
        check("sh_mem_word", bus_word(768) & 32'h0000_FFFF, 32'h0000_5678);

        run_op(OP_SH, 32'h0000_0301, 32'h0, 0, 0);
        run_op(OP_LH, 32'h0000_0302, 32'h0, 0, 0);
        run_op(OP_SW, 32'h0000_0302, 32'h0, 0, 0);

        // Reset while a load waits for data
        instr        = make_instr(OP_LW);
        alu_result   = 32'h0000_0100;
        enabled      = 1'b1;
        step();
        enabled      = 1'b0;
        m_gnt        = 1'b1;
        step();
        m_gnt        = 1'b0;
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("abort_wait");
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hDEAD_BEEF;
            step();
            check("abort_no_completed", {31'b0, completed}, 32'd0);
        end
        m_rvalid = 1'b0;

        // Reset while the request is still waiting for grant
        instr      = make_instr(OP_SW);
        alu_result = 32'h0000_0104;
        enabled    = 1'b1;
        step();
        enabled    = 1'b0;
        check("abort_req_before", {31'b0, m_req}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("abort_req");
        @(posedge clk);
        #1 rstn = 1'b1;
        step();

        run_op(OP_LW, 32'h0000_0100, 32'h0, 1, 1);
        check("post_reset_lw", result, ref_word(256));

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            code = $urandom_range(0, 10);
            if (code <= OP_LUI) begin
                addr = $urandom;
            end else begin
                sz = op_size(code);
                a  = $urandom_range(0, 1023);
                if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
                addr = 32'(a);
            end
            run_op(code, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
